dbus_req_arbiter: RTL and testbench
===================================

// Module: dbus_req_arbiter
// PURPOSE
//  Shares the single data-cache CPU port (cpu_dbus) between two requesters: MEM-stage load/store (port m) and store-buffer drain (port s).
//  Tracks outstanding requests in an in-order owner FIFO and routes each data_ok/rdata back to its owner. MEM2 consumes the routed read data.
//  Drops responses for pipeline requests killed by a MEM/MEM2 flush. Bounds store-buffer starvation with a wait counter.
// PARAMETERS
//  MAX_OUTSTANDING  2  max requests accepted by the cache whose data_ok is still pending (owner FIFO depth)
//  STARVE_LIMIT     8  consecutive ungranted cycles with s_req=1 before port s takes priority
// PORTS
//  clk         in   1   clock, rising edge
//  resetn      in   1   asynchronous, active-low reset
//  m_req       in   1   pipeline request valid
//  m_wr        in   1   1=store, 0=load
//  m_size      in   2   0=byte 1=half 2=word
//  m_addr      in   32  byte address
//  m_wdata     in   32  store data
//  m_wstrb     in   4   byte enables
//  m_kill      in   1   flush: masks m_req this cycle; marks all outstanding port-m entries as discarded
//  m_addr_ok   out  1   pipeline request accepted this cycle
//  m_data_ok   out  1   pipeline response valid
//  m_rdata     out  32  load data (d_rdata passthrough)
//  s_req       in   1   store-buffer drain request (always a write, word size)
//  s_addr      in   32  byte address
//  s_wdata     in   32  store data
//  s_wstrb     in   4   byte enables
//  s_addr_ok   out  1   drain request accepted this cycle
//  s_data_ok   out  1   drain write completed
//  d_req,d_wr  out  1,1 cache request valid / write
//  d_size      out  2   muxed size
//  d_addr      out  32  muxed address
//  d_wdata     out  32  muxed write data
//  d_wstrb     out  4   muxed byte enables
//  d_addr_ok   in   1   cache accepted request
//  d_data_ok   in   1   cache response (strictly in request order)
//  d_rdata     in   32  cache read data
//  busy        out  1   owner FIFO non-empty
//  proto_err   out  1   sticky: d_data_ok seen with empty FIFO
// BEHAVIOUR
//  - Reset: FIFO count/pointers=0, starve counter=0, proto_err=0; with no requests all out valids are 0.
//  - Eligible: m_eff=m_req&~m_kill; s_eff=s_req. full = (count==MAX_OUTSTANDING).
//  - Grant (combinational): starve=(cnt>=STARVE_LIMIT). If starve & s_eff -> s; else if m_eff -> m; else if s_eff -> s.
//  - d_req = granted & ~full; d_* fields muxed from the granted port (s drives d_wr=1, d_size=2).
//  - Accept = d_req & d_addr_ok: granted port's addr_ok=1 the same cycle (zero latency); push {owner,discard=0}.
//  - Full blocks push even if a pop occurs in the same cycle; push+pop when not full leaves count unchanged.
//  - Requesters hold all fields stable from req=1 until their addr_ok.
//  - d_data_ok pops the FIFO head. If owner=m and ~discard: m_data_ok=1. If owner=s: s_data_ok=1 (never discarded).
//    Discarded entries pop silently. Response latency is zero cycles (combinational route).
//  - m_kill: sets discard on every valid owner=m entry, including the head popped that same cycle (its m_data_ok is suppressed).
//  - Starve counter: +1 (saturating at STARVE_LIMIT) each cycle s_req=1 without s_addr_ok; cleared on s_addr_ok or s_req=0.
//  - d_data_ok with count==0: ignored, proto_err<=1 until reset.
//  - Reset mid-transaction clears all state; responses for pre-reset requests become proto_err events.
// TESTING
//  1. m load addr 0x80001000 only, d_addr_ok=1, d_data_ok next cycle rdata 0xDEADBEEF -> m_addr_ok cycle0, m_data_ok+m_rdata=0xDEADBEEF cycle1.
//  2. m_req and s_req both held, cache always ready -> m wins 8 cycles, cycle 9 s_addr_ok=1, counter clears, then m resumes.
//  3. Cache holds d_data_ok=0, two m accepts -> full; third m_req sees d_req=0, m_addr_ok=0 until first d_data_ok, then next-cycle accept.
//  4. Two m loads outstanding, m_kill pulsed, two d_data_ok -> no m_data_ok, busy falls to 0, new m request accepted normally.
//  5. Interleaved s write then m load outstanding, m_kill -> s_data_ok=1 on first response, m response dropped.
//  6. d_data_ok with empty FIFO -> proto_err=1 and stays 1; resetn=0 asynchronously clears it and busy.

Source files
------------

// File: rtl/dbus_req_arbiter.sv
// Shares the data-cache CPU port between the MEM-stage pipeline (port m) and the store-buffer drain (port s).
// An in-order owner FIFO routes each response back to its requester and drops responses for flushed pipeline requests.
module dbus_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m_req,
    input  logic        m_wr,
    input  logic [1:0]  m_size,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    input  logic        m_kill,
    output logic        m_addr_ok,
    output logic        m_data_ok,
    output logic [31:0] m_rdata,

    input  logic        s_req,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_addr_ok,
    output logic        s_data_ok,

    output logic        d_req,
    output logic        d_wr,
    output logic [1:0]  d_size,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    output logic [3:0]  d_wstrb,
    input  logic        d_addr_ok,
    input  logic        d_data_ok,
    input  logic [31:0] d_rdata,

    output logic        busy,
    output logic        proto_err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic OWNER_M = 1'b0;
    localparam logic OWNER_S = 1'b1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve_cnt;

    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [MAX_OUTSTANDING-1:0] discard_q;
    logic [MAX_OUTSTANDING-1:0] valid_q;

    logic m_eff;
    logic s_eff;
    logic starve;
    logic grant_m;
    logic grant_s;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_owner;
    logic head_discard;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign m_eff  = m_req & ~m_kill;
    assign s_eff  = s_req;
    assign starve = (starve_cnt >= STV_W'(STARVE_LIMIT));
    assign full   = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty  = (count == '0);

    // A starved drain overrides the pipeline; otherwise the pipeline always wins.
    assign grant_s = s_eff & (starve | ~m_eff);
    assign grant_m = m_eff & ~(starve & s_eff);

    always_comb begin
        d_req   = (grant_m | grant_s) & ~full;
        d_wr    = m_wr;
        d_size  = m_size;
        d_addr  = m_addr;
        d_wdata = m_wdata;
        d_wstrb = m_wstrb;
        if (grant_s) begin
            d_wr    = 1'b1;
            d_size  = 2'd2;
            d_addr  = s_addr;
            d_wdata = s_wdata;
            d_wstrb = s_wstrb;
        end
    end

    assign push      = d_req & d_addr_ok;
    assign m_addr_ok = push & grant_m;
    assign s_addr_ok = push & grant_s;

    assign pop          = d_data_ok & ~empty;
    assign head_owner   = owner_q[rd_ptr];
    assign head_discard = discard_q[rd_ptr];

    // A kill in the same cycle as the head response suppresses that response too.
    assign m_data_ok = pop & (head_owner == OWNER_M) & ~head_discard & ~m_kill;
    assign s_data_ok = pop & (head_owner == OWNER_S);
    assign m_rdata   = d_rdata;
    assign busy      = ~empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q   <= '0;
            discard_q <= '0;
            valid_q   <= '0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (m_kill && valid_q[i] && (owner_q[i] == OWNER_M)) begin
                    discard_q[i] <= 1'b1;
                end
            end
            // Push and pop never address the same slot: pop needs count>0, push needs count<MAX.
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
            end
            if (push) begin
                valid_q[wr_ptr]   <= 1'b1;
                owner_q[wr_ptr]   <= grant_s ? OWNER_S : OWNER_M;
                discard_q[wr_ptr] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (s_req && !s_addr_ok) begin
            if (!starve) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            proto_err <= 1'b0;
        end else if (d_data_ok && empty) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dbus_req_arbiter.sv
// Directed bench for dbus_req_arbiter: a per-cycle vector table plus hand sequences for
// starvation, saturation and asynchronous reset.
module tb_dbus_req_arbiter;

    localparam logic [31:0] M_ADDR  = 32'h8000_1000;
    localparam logic [31:0] S_ADDR  = 32'h0000_2000;
    localparam logic [31:0] M_WDATA = 32'hAAAA_0000;
    localparam logic [31:0] S_WDATA = 32'h5555_FFFF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m_req = 1'b0, m_wr = 1'b0, m_kill = 1'b0;
    logic [1:0]  m_size = 2'd0;
    logic [31:0] m_addr = M_ADDR, m_wdata = M_WDATA;
    logic [3:0]  m_wstrb = 4'h1;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        s_req = 1'b0;
    logic [31:0] s_addr = S_ADDR, s_wdata = S_WDATA;
    logic [3:0]  s_wstrb = 4'hF;
    logic        s_addr_ok, s_data_ok;
    logic        d_req, d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_addr_ok = 1'b0, d_data_ok = 1'b0;
    logic [31:0] d_rdata = 32'h0;
    logic        busy, proto_err;

    int n_cmp = 0;
    int n_err = 0;

    dbus_req_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(8)) dut (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_kill(m_kill),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m_req, m_wr, m_kill, s_req, aok, dok;
        logic [31:0] rdata;
        logic        e_dreq, e_maok, e_saok, e_mdok, e_sdok, e_busy, e_perr;
        logic [1:0]  e_gnt;   // 0 none, 1 m, 2 s (only checked when e_dreq)
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic mr, input logic mw, input logic mk_, input logic sr,
                                input logic aok, input logic dok, input logic [31:0] rd,
                                input logic dreq, input logic maok, input logic saok,
                                input logic mdok, input logic sdok, input logic bsy,
                                input logic perr, input logic [1:0] gnt);
        vec_t v;
        v.m_req = mr; v.m_wr = mw; v.m_kill = mk_; v.s_req = sr; v.aok = aok; v.dok = dok;
        v.rdata = rd; v.e_dreq = dreq; v.e_maok = maok; v.e_saok = saok; v.e_mdok = mdok;
        v.e_sdok = sdok; v.e_busy = bsy; v.e_perr = perr; v.e_gnt = gnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mr, input logic mw, input logic mk_, input logic sr,
                         input logic aok, input logic dok, input logic [31:0] rd);
        @(negedge clk);
        m_req = mr; m_wr = mw; m_kill = mk_; s_req = sr;
        d_addr_ok = aok; d_data_ok = dok; d_rdata = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        m_req = 0; m_kill = 0; s_req = 0; d_addr_ok = 0; d_data_ok = 0;
        resetn = 0;
        @(negedge clk);
        resetn = 1;
    endtask

    initial begin
        //              mr mw mk sr ak dk rdata         dreq maok saok mdok sdok busy perr gnt
        vecs[0]  = mk(1, 0, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0, 2'd1);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1, 32'hDEADBEEF,   0, 0, 0, 1, 0, 1, 0, 2'd0);
        vecs[2]  = mk(1, 0, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0, 2'd1);
        vecs[3]  = mk(1, 0, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 1, 0, 2'd1);
        vecs[4]  = mk(1, 0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 0, 2'd0);
        vecs[5]  = mk(1, 0, 0, 0, 1, 1, 32'h11111111,   0, 0, 0, 1, 0, 1, 0, 2'd0);
        vecs[6]  = mk(1, 0, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 1, 0, 2'd1);
        vecs[7]  = mk(0, 0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 1, 0, 2'd0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 1, 32'h0,          0, 0, 0, 0, 0, 1, 0, 2'd0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 1, 32'h0,          0, 0, 0, 0, 0, 1, 0, 2'd0);
        vecs[10] = mk(1, 0, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0, 2'd1);
        vecs[11] = mk(0, 0, 0, 0, 0, 1, 32'h22222222,   0, 0, 0, 1, 0, 1, 0, 2'd0);
        vecs[12] = mk(0, 0, 0, 1, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0, 2'd2);
        vecs[13] = mk(1, 0, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 1, 0, 2'd1);
        vecs[14] = mk(0, 0, 1, 0, 0, 1, 32'h0,          0, 0, 0, 0, 1, 1, 0, 2'd0);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 32'h33333333,   0, 0, 0, 0, 0, 1, 0, 2'd0);
        vecs[16] = mk(1, 0, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0, 2'd1);
        vecs[17] = mk(0, 0, 1, 0, 0, 1, 32'h44444444,   0, 0, 0, 0, 0, 1, 0, 2'd0);
        vecs[18] = mk(1, 1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0, 2'd1);
        vecs[19] = mk(0, 0, 0, 0, 0, 1, 32'h0,          0, 0, 0, 1, 0, 1, 0, 2'd0);
        vecs[20] = mk(1, 0, 1, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 2'd0);
        vecs[21] = mk(1, 0, 0, 1, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0, 2'd1);
        vecs[22] = mk(0, 0, 0, 1, 1, 1, 32'h55555555,   1, 0, 1, 1, 0, 1, 0, 2'd2);
        vecs[23] = mk(0, 0, 0, 0, 0, 1, 32'h0,          0, 0, 0, 0, 1, 1, 0, 2'd0);
        vecs[24] = mk(0, 0, 0, 0, 0, 1, 32'h0,          0, 0, 0, 0, 0, 0, 0, 2'd0);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1, 2'd0);

        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_perr", proto_err, 0);
        check("reset_dreq", d_req, 0);
        resetn = 1;

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].m_req, vecs[i].m_wr, vecs[i].m_kill, vecs[i].s_req,
                  vecs[i].aok, vecs[i].dok, vecs[i].rdata);
            check($sformatf("v%0d_d_req", i), d_req, vecs[i].e_dreq);
            check($sformatf("v%0d_m_addr_ok", i), m_addr_ok, vecs[i].e_maok);
            check($sformatf("v%0d_s_addr_ok", i), s_addr_ok, vecs[i].e_saok);
            check($sformatf("v%0d_m_data_ok", i), m_data_ok, vecs[i].e_mdok);
            check($sformatf("v%0d_s_data_ok", i), s_data_ok, vecs[i].e_sdok);
            check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("v%0d_proto_err", i), proto_err, vecs[i].e_perr);
            if (vecs[i].e_mdok) begin
                check($sformatf("v%0d_m_rdata", i), m_rdata, vecs[i].rdata);
            end
            if (vecs[i].e_dreq && vecs[i].e_gnt == 2'd1) begin
                check($sformatf("v%0d_d_addr_m", i), d_addr, M_ADDR);
                check($sformatf("v%0d_d_wdata_m", i), d_wdata, M_WDATA);
                check($sformatf("v%0d_d_size_m", i), d_size, 2'd0);
                check($sformatf("v%0d_d_wr_m", i), d_wr, vecs[i].m_wr);
                check($sformatf("v%0d_d_wstrb_m", i), d_wstrb, 4'h1);
            end
            if (vecs[i].e_dreq && vecs[i].e_gnt == 2'd2) begin
                check($sformatf("v%0d_d_addr_s", i), d_addr, S_ADDR);
                check($sformatf("v%0d_d_wdata_s", i), d_wdata, S_WDATA);
                check($sformatf("v%0d_d_size_s", i), d_size, 2'd2);
                check($sformatf("v%0d_d_wr_s", i), d_wr, 1'b1);
                check($sformatf("v%0d_d_wstrb_s", i), d_wstrb, 4'hF);
            end
        end

        // Asynchronous reset with a request outstanding and proto_err set.
        drive(1, 0, 0, 0, 1, 0, 32'h0);
        check("ar_accept", m_addr_ok, 1);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        check("ar_busy_before", busy, 1);
        check("ar_perr_before", proto_err, 1);
        #2 resetn = 0;
        #1;
        check("ar_busy_async", busy, 0);
        check("ar_perr_async", proto_err, 0);
        @(negedge clk);
        resetn = 1;
        drive(0, 0, 0, 0, 0, 1, 32'h66666666);
        check("ar_stale_mdok", m_data_ok, 0);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        check("ar_stale_perr", proto_err, 1);

        // Starvation: m wins 8 cycles, s on the 9th, then m resumes.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drive(1, 0, 0, 1, 1, (c > 0), 32'h0);
            check($sformatf("stv%0d_m_addr_ok", c), m_addr_ok, (c != 8));
            check($sformatf("stv%0d_s_addr_ok", c), s_addr_ok, (c == 8));
            if (c == 9) begin
                check("stv9_s_data_ok", s_data_ok, 1);
            end
        end
        drive(0, 0, 0, 0, 0, 1, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        check("stv_drained", busy, 0);

        // Counter saturates while the cache stalls; s must still win afterwards.
        for (int c = 0; c < 20; c++) begin
            drive(1, 0, 0, 1, 0, 0, 32'h0);
            if (c == 19) begin
                check("sat_stall_s_addr_ok", s_addr_ok, 0);
            end
        end
        drive(1, 0, 0, 1, 1, 0, 32'h0);
        check("sat_s_addr_ok", s_addr_ok, 1);
        check("sat_m_addr_ok", m_addr_ok, 0);
        drive(1, 0, 0, 0, 1, 1, 32'h0);
        check("sat_m_resume", m_addr_ok, 1);
        check("sat_s_data_ok", s_data_ok, 1);
        drive(0, 0, 0, 0, 0, 1, 32'h77777777);
        check("sat_m_data_ok", m_data_ok, 1);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        check("sat_end_busy", busy, 0);
        check("sat_end_perr", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
